// File: rtl/banco_registradores_pkg.sv
// banco_registradores_pkg: shared widths, stack pointer reset and selRT encodings
package banco_registradores_pkg;
    localparam int LARGURA = 32;
    localparam int NUM_REGS = 32;
    localparam int REG_SP = 29;
    localparam logic [LARGURA-1:0] SP_INICIAL = 32'h0000_03FC;
    localparam logic [1:0] SEL_REG = 2'b00;
    localparam logic [1:0] SEL_HI = 2'b01;
    localparam logic [1:0] SEL_LO = 2'b10;
    localparam logic [1:0] SEL_ZERO = 2'b11;
endpackage

// File: rtl/banco_registradores_par_hilo.sv
// par_hilo: HI/LO multiply result pair, both halves written together
module par_hilo #(
    parameter int LARGURA = banco_registradores_pkg::LARGURA
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               escreve,
    input  logic [LARGURA-1:0] entradaHI,
    input  logic [LARGURA-1:0] entradaLO,
    output logic [LARGURA-1:0] hi,
    output logic [LARGURA-1:0] lo
);
    always_ff @(posedge clock) begin
        if (!reset) begin
            hi <= '0;
            lo <= '0;
        end else if (escreve) begin
            hi <= entradaHI;
            lo <= entradaLO;
        end
    end
endmodule

// File: rtl/banco_registradores.sv
// banco_registradores: 32x32 register file with HI/LO pair and registered, write-through read ports
module banco_registradores #(
    parameter int NUM_REGS = banco_registradores_pkg::NUM_REGS,
    parameter int LARGURA = banco_registradores_pkg::LARGURA,
    parameter int REG_SP = banco_registradores_pkg::REG_SP,
    parameter logic [LARGURA-1:0] SP_INICIAL = banco_registradores_pkg::SP_INICIAL
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [4:0]         endRS,
    input  logic [4:0]         endRT,
    input  logic [4:0]         endEscrita,
    input  logic [LARGURA-1:0] dadoEscrita,
    input  logic               escreveReg,
    input  logic               escreveHILO,
    input  logic [LARGURA-1:0] entradaHI,
    input  logic [LARGURA-1:0] entradaLO,
    input  logic [1:0]         selRT,
    output logic [LARGURA-1:0] RS,
    output logic [LARGURA-1:0] RT
);
    import banco_registradores_pkg::*;
    logic [LARGURA-1:0] regs [NUM_REGS];
    logic [LARGURA-1:0] hi, lo, rs_prox, rt_reg, rt_prox;
    logic escreve;
    par_hilo #(.LARGURA(LARGURA)) u_hilo (
        .clock(clock),
        .reset(reset),
        .escreve(escreveHILO),
        .entradaHI(entradaHI),
        .entradaLO(entradaLO),
        .hi(hi),
        .lo(lo)
    );
    assign escreve = escreveReg && (endEscrita != 5'd0);
    // same-cycle writes are forwarded so the consumer never sees a stale value
    assign rs_prox = (endRS == 5'd0) ? '0 : (escreve && endEscrita == endRS) ? dadoEscrita : regs[endRS];
    assign rt_reg = (endRT == 5'd0) ? '0 : (escreve && endEscrita == endRT) ? dadoEscrita : regs[endRT];
    assign rt_prox = (selRT == SEL_REG) ? rt_reg :
                     (selRT == SEL_HI) ? (escreveHILO ? entradaHI : hi) :
                     (selRT == SEL_LO) ? (escreveHILO ? entradaLO : lo) : '0;
    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= (i == REG_SP) ? SP_INICIAL : '0;
            RS <= '0;
            RT <= '0;
        end else begin
            if (escreve) regs[endEscrita] <= dadoEscrita;
            RS <= rs_prox;
            RT <= rt_prox;
        end
    end
endmodule

// File: tb/tb_banco_registradores.sv
// tb_banco_registradores: random and directed stimulus against an array-based reference model
module tb_banco_registradores;
    logic clock = 1'b0;
    logic reset;
    logic [4:0] endRS, endRT, endEscrita;
    logic [31:0] dadoEscrita, entradaHI, entradaLO;
    logic escreveReg, escreveHILO;
    logic [1:0] selRT;
    logic [31:0] RS, RT;
    logic [31:0] m_regs [32];
    logic [31:0] m_hi, m_lo, exp_rs, exp_rt;
    logic chk_en = 1'b0;
    int total = 0;
    int bad = 0;
    banco_registradores dut (
        .clock(clock),
        .reset(reset),
        .endRS(endRS),
        .endRT(endRT),
        .endEscrita(endEscrita),
        .dadoEscrita(dadoEscrita),
        .escreveReg(escreveReg),
        .escreveHILO(escreveHILO),
        .entradaHI(entradaHI),
        .entradaLO(entradaLO),
        .selRT(selRT),
        .RS(RS),
        .RT(RT)
    );
    always #5 clock = ~clock;
    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h at %0t", nm, got, want, $time);
        end
    endtask
    always @(negedge clock) begin
        if (chk_en) begin
            chk("RS", RS, exp_rs);
            chk("RT", RT, exp_rt);
        end
    end
    function automatic logic [31:0] rd(input logic [4:0] a, input logic wv, input logic [4:0] wa, input logic [31:0] wd);
        return (a == 5'd0) ? 32'd0 : (wv && wa == a) ? wd : m_regs[a];
    endfunction
    task automatic step(input logic rst, input logic we, input logic [4:0] wa, input logic [31:0] wd,
                        input logic hw, input logic [31:0] ih, input logic [31:0] il,
                        input logic [4:0] ars, input logic [4:0] art, input logic [1:0] sel);
        logic wv;
        @(negedge clock);
        #1;
        reset = rst; escreveReg = we; endEscrita = wa; dadoEscrita = wd;
        escreveHILO = hw; entradaHI = ih; entradaLO = il;
        endRS = ars; endRT = art; selRT = sel;
        if (!rst) begin
            exp_rs = 32'd0;
            exp_rt = 32'd0;
            for (int i = 0; i < 32; i++) m_regs[i] = (i == 29) ? 32'h0000_03FC : 32'd0;
            m_hi = 32'd0;
            m_lo = 32'd0;
        end else begin
            wv = we && (wa != 5'd0);
            exp_rs = rd(ars, wv, wa, wd);
            case (sel)
                2'b00: exp_rt = rd(art, wv, wa, wd);
                2'b01: exp_rt = hw ? ih : m_hi;
                2'b10: exp_rt = hw ? il : m_lo;
                default: exp_rt = 32'd0;
            endcase
            if (wv) m_regs[wa] = wd;
            if (hw) begin
                m_hi = ih;
                m_lo = il;
            end
        end
        chk_en = 1'b1;
        @(posedge clock);
        #1;
    endtask
    task automatic pin(input string nm, input logic [31:0] want_rs, input logic [31:0] want_rt);
        chk({nm, "_rs"}, RS, want_rs);
        chk({nm, "_rt"}, RT, want_rt);
        chk({nm, "_model_rs"}, exp_rs, want_rs);
        chk({nm, "_model_rt"}, exp_rt, want_rt);
    endtask
    initial begin
        logic [4:0] a0, a1, a2;
        reset = 1'b0; escreveReg = 1'b0; escreveHILO = 1'b0; endEscrita = '0; dadoEscrita = '0;
        entradaHI = '0; entradaLO = '0; endRS = '0; endRT = '0; selRT = 2'b00;
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00);
        pin("reset", 32'd0, 32'd0);
        step(1, 0, 0, 0, 0, 0, 0, 29, 5, 2'b00);
        pin("sp_init", 32'h0000_03FC, 32'd0);
        step(1, 0, 0, 0, 0, 0, 0, 29, 5, 2'b01);
        pin("hi_init", 32'h0000_03FC, 32'd0);
        step(1, 0, 0, 0, 0, 0, 0, 29, 5, 2'b10);
        pin("lo_init", 32'h0000_03FC, 32'd0);
        step(1, 1, 7, 32'hDEADBEEF, 0, 0, 0, 0, 0, 2'b00);
        step(1, 0, 0, 0, 0, 0, 0, 7, 0, 2'b00);
        pin("r7", 32'hDEADBEEF, 32'd0);
        step(1, 1, 0, 32'h12345678, 0, 0, 0, 0, 0, 2'b00);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00);
        pin("r0", 32'd0, 32'd0);
        step(1, 1, 9, 32'hA5A5A5A5, 0, 0, 0, 9, 9, 2'b00);
        pin("bypass", 32'hA5A5A5A5, 32'hA5A5A5A5);
        step(1, 0, 0, 0, 0, 0, 0, 9, 9, 2'b00);
        step(1, 0, 0, 0, 0, 0, 0, 9, 9, 2'b00);
        pin("hold", 32'hA5A5A5A5, 32'hA5A5A5A5);
        step(1, 0, 0, 0, 1, 32'h1, 32'h2, 7, 0, 2'b01);
        pin("hi_byp", 32'hDEADBEEF, 32'h1);
        step(1, 0, 0, 0, 0, 0, 0, 7, 0, 2'b10);
        pin("lo_rd", 32'hDEADBEEF, 32'h2);
        step(1, 0, 0, 0, 0, 0, 0, 7, 9, 2'b11);
        pin("zero_sel", 32'hDEADBEEF, 32'd0);
        step(0, 1, 3, 32'hFF, 1, 32'hFF, 32'hFF, 3, 3, 2'b00);
        pin("rst_mid", 32'd0, 32'd0);
        step(1, 0, 0, 0, 0, 0, 0, 3, 0, 2'b01);
        pin("rst_r3_hi", 32'd0, 32'd0);
        step(1, 0, 0, 0, 0, 0, 0, 7, 3, 2'b10);
        pin("rst_r7_lo", 32'd0, 32'd0);
        repeat (3000) begin
            a0 = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
            a1 = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
            a2 = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
            step($urandom_range(0, 63) != 0, 1'($urandom_range(0, 1)), a0, $urandom,
                 $urandom_range(0, 3) == 0, $urandom, $urandom, a1, a2, 2'($urandom_range(0, 3)));
        end
        @(negedge clock);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/banco_registradores.md
Name: banco_registradores

Overview:
- 32x32 general-purpose register file with HI/LO pair; sits directly upstream of the ULA and drives its RS/RT operand inputs.
- Captures the ULA's multiply result (saidaHI/saidaLO) into HI/LO and supplies HI/LO back on the RT path for move-from-HI/LO instructions.
- Registered read ports: operands are valid one cycle after the addresses are presented.

Parameters:
- NUM_REGS, 32, number of architectural registers (address width fixed at 5).
- LARGURA, 32, data width.
- REG_SP, 29, index of the stack pointer register.
- SP_INICIAL, 32'h0000_03FC, reset value of register REG_SP.

Ports:
- clock  in  1  system clock, all state updates on rising edge.
- reset  in  1  synchronous, active-low reset.
- endRS  in  5  read address, port RS.
- endRT  in  5  read address, port RT.
- endEscrita  in  5  write address.
- dadoEscrita  in  32  write data (writeback value).
- escreveReg  in  1  write enable, register file.
- escreveHILO  in  1  write enable, HI and LO together.
- entradaHI  in  32  HI write data (from ULA saidaHI).
- entradaLO  in  32  LO write data (from ULA saidaLO).
- selRT  in  2  RT output source: 00 register[endRT], 01 HI, 10 LO, 11 zero.
- RS  out  32  registered operand to ULA RS.
- RT  out  32  registered operand to ULA RT.

Behaviour:
- Reset (reset==0 at rising edge): all registers cleared to 0 except register REG_SP = SP_INICIAL; HI=LO=0; RS=RT=0. Reset has priority over every write and read in that cycle; a write pending in the reset cycle is discarded.
- Register 0 hardwired to zero: writes with endEscrita==0 are ignored; reads of address 0 return 0.
- Write: on rising edge with escreveReg==1 and endEscrita!=0, register[endEscrita] <= dadoEscrita.
- HI/LO write: on rising edge with escreveHILO==1, HI <= entradaHI and LO <= entradaLO in the same edge. It is independent of escreveReg; both may occur in the same cycle.
- Read latency: exactly 1 cycle. RS/RT at edge N+1 reflect the addresses and selRT sampled at edge N.
- Write-through bypass: if escreveReg==1, endEscrita!=0, and endEscrita equals endRS (or endRT with selRT==00) in the same cycle, the corresponding output latches dadoEscrita, not the stale register value.
- HI/LO bypass: if escreveHILO==1 and selRT is 01 or 10 in the same cycle, RT latches entradaHI or entradaLO respectively.
- selRT==11: RT latches 0.
- Both ports may read the same address simultaneously; both receive identical data, including the bypassed value.
- No stall or valid handshake: outputs update every cycle. Holding the inputs constant holds the outputs constant.
- No arithmetic is performed; widths are fixed, with no sign extension.

Decomposition:
- Shared package: LARGURA, the REG_SP index, and the selRT encodings (SEL_REG=2'b00, SEL_HI=2'b01, SEL_LO=2'b10, SEL_ZERO=2'b11), reused by the control unit that drives selRT.
- One natural sub-module: par_hilo (HI/LO registers plus their write enable), instantiated once. The register array and the read/bypass muxing stay in the top.

Test Plan:
- Reset: hold reset=0 for 2 cycles, then read addresses 29 and 5 -> RS=32'h0000_03FC, RT=0 one cycle later; HI/LO reads return 0.
- Write then read: write 32'hDEADBEEF to r7, next cycle endRS=7 -> RS=32'hDEADBEEF one cycle later.
- Zero register: write 32'h12345678 to r0, then read r0 on both ports -> RS=RT=0.
- Same-cycle bypass: write 32'hA5A5A5A5 to r9 while endRS=endRT=9, selRT=00 -> RS=RT=32'hA5A5A5A5 on the next edge.
- HI/LO capture and bypass: escreveHILO=1 with entradaHI=32'h1, entradaLO=32'h2 and selRT=01 -> RT=32'h1 next edge; following cycle selRT=10 -> RT=32'h2; selRT=11 -> RT=0.
- Reset mid-write: reset=0 coincident with escreveReg=1 to r3 (32'hFF) and escreveHILO=1 -> after release, r3, HI and LO all read 0 and RS=RT=0.
